// File: rtl/ahb_master_engine.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined single-beat
// NONSEQ transfers, returning one in-order response per command, with a wait-state watchdog.
module ahb_master_engine #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              HCLK,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  output logic              busy
);

  localparam int CW = $clog2(MAX_WAIT);

  logic              a_vld_reg, a_vld_next;
  logic              a_write_reg, a_write_next;
  logic [ADDR_W-1:0] a_addr_reg, a_addr_next;
  logic [DATA_W-1:0] a_wdata_reg, a_wdata_next;
  logic              d_vld_reg, d_vld_next;
  logic              d_write_reg, d_write_next;
  logic [DATA_W-1:0] d_wdata_reg, d_wdata_next;
  logic              abt_reg, abt_next;
  logic [CW-1:0]     wait_cnt_reg, wait_cnt_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_write_reg, rsp_write_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;

  logic timeout_now;
  logic accept;
  logic advance;
  logic complete;

  assign timeout_now = d_vld_reg && !HREADY && (wait_cnt_reg == CW'(MAX_WAIT - 1));
  assign cmd_ready   = !reset && !abt_reg && !timeout_now && (!a_vld_reg || HREADY);
  assign accept      = cmd_valid && cmd_ready;
  assign advance     = a_vld_reg && HREADY;
  assign complete    = d_vld_reg && HREADY;

  always_comb begin
    a_vld_next     = a_vld_reg;
    a_write_next   = a_write_reg;
    a_addr_next    = a_addr_reg;
    a_wdata_next   = a_wdata_reg;
    d_vld_next     = d_vld_reg;
    d_write_next   = d_write_reg;
    d_wdata_next   = d_wdata_reg;
    abt_next       = 1'b0;
    wait_cnt_next  = wait_cnt_reg;
    rsp_valid_next = 1'b0;
    rsp_write_next = rsp_write_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = 1'b0;

    if (timeout_now) begin
      // Hung data phase: retire D with an error and park any address-phase command in ABORT
      d_vld_next     = 1'b0;
      wait_cnt_next  = '0;
      rsp_valid_next = 1'b1;
      rsp_write_next = d_write_reg;
      rsp_rdata_next = '0;
      rsp_err_next   = 1'b1;
      if (a_vld_reg) begin
        a_vld_next = 1'b0;
        abt_next   = 1'b1;
      end
    end else if (abt_reg) begin
      // a_write_reg still holds the aborted command since no accept can occur meanwhile
      rsp_valid_next = 1'b1;
      rsp_write_next = a_write_reg;
      rsp_rdata_next = '0;
      rsp_err_next   = 1'b1;
    end else begin
      if (complete) begin
        rsp_valid_next = 1'b1;
        rsp_write_next = d_write_reg;
        rsp_rdata_next = d_write_reg ? '0 : HRDATA;
        wait_cnt_next  = '0;
        d_vld_next     = 1'b0;
      end else if (d_vld_reg) begin
        wait_cnt_next = wait_cnt_reg + CW'(1);
      end else begin
        wait_cnt_next = '0;
      end

      if (advance) begin
        d_vld_next   = 1'b1;
        d_write_next = a_write_reg;
        d_wdata_next = a_wdata_reg;
        a_vld_next   = 1'b0;
      end

      if (accept) begin
        a_vld_next   = 1'b1;
        a_write_next = cmd_write;
        a_addr_next  = cmd_addr;
        a_wdata_next = cmd_wdata;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (reset) begin
      a_vld_reg     <= 1'b0;
      a_write_reg   <= 1'b0;
      a_addr_reg    <= '0;
      a_wdata_reg   <= '0;
      d_vld_reg     <= 1'b0;
      d_write_reg   <= 1'b0;
      d_wdata_reg   <= '0;
      abt_reg       <= 1'b0;
      wait_cnt_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      a_vld_reg     <= a_vld_next;
      a_write_reg   <= a_write_next;
      a_addr_reg    <= a_addr_next;
      a_wdata_reg   <= a_wdata_next;
      d_vld_reg     <= d_vld_next;
      d_write_reg   <= d_write_next;
      d_wdata_reg   <= d_wdata_next;
      abt_reg       <= abt_next;
      wait_cnt_reg  <= wait_cnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_write_reg <= rsp_write_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  // Slot A address/direction registers only load on accept, so they hold through waits and idle
  assign HTRANS    = a_vld_reg ? 2'b10 : 2'b00;
  assign HADDR     = a_addr_reg;
  assign HWRITE    = a_write_reg;
  assign HWDATA    = d_wdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_write = rsp_write_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = a_vld_reg || d_vld_reg || abt_reg;

endmodule

// File: tb/tb_ahb_master_engine.sv
// Directed bench for ahb_master_engine against a small 8-word AHB SRAM slave model.
module tb_ahb_master_engine;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          HCLK = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] HADDR;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HWDATA, HRDATA;
  logic          HREADY;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_master_engine #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .HCLK(HCLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .busy(busy)
  );

  // Slave model: latch the address phase when HREADY, write memory at the end of the data phase
  logic [DW-1:0] mem [0:7];
  logic          dp_vld, dp_write;
  logic [2:0]    dp_addr;

  always @(posedge HCLK) begin
    if (reset) begin
      dp_vld <= 1'b0;
    end else if (HREADY) begin
      if (dp_vld && dp_write) mem[dp_addr] <= HWDATA;
      dp_vld   <= (HTRANS == 2'b10);
      dp_write <= HWRITE;
      dp_addr  <= HADDR[2:0];
    end
  end

  assign HRDATA = dp_vld ? mem[dp_addr] : '0;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    int k;
    reset  = 1'b1;
    HREADY = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();

    // Reset values
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", HWRITE, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);

    // Single write, zero wait states
    drive(1'b1, 1'b1, 32'd3, 32'hA5A50001);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    chk("sw_htrans", HTRANS, 2'b10);
    chk("sw_haddr", HADDR, 3);
    chk("sw_hwrite", HWRITE, 1);
    chk("sw_rsp_early", rsp_valid, 0);
    tick();
    chk("sw_hwdata", HWDATA, 32'hA5A50001);
    chk("sw_htrans_idle", HTRANS, 2'b00);
    chk("sw_rsp_early2", rsp_valid, 0);
    tick();
    chk("sw_rsp_valid", rsp_valid, 1);
    chk("sw_rsp_write", rsp_write, 1);
    chk("sw_rsp_err", rsp_err, 0);
    chk("sw_rsp_rdata", rsp_rdata, 0);
    tick();
    chk("sw_rsp_pulse", rsp_valid, 0);
    chk("sw_busy", busy, 0);

    // Back-to-back: writes 0..4 then reads 0..4
    drive(1'b1, 1'b1, 32'd0, 32'h10);
    #1;
    chk("b2b_ready", cmd_ready, 1);
    for (int c = 1; c <= 13; c++) begin
      tick();
      k = c - 3;
      chk("b2b_htrans", HTRANS, (c <= 10) ? 2'b10 : 2'b00);
      chk("b2b_rsp_valid", rsp_valid, (c >= 3 && c <= 12) ? 1 : 0);
      if (c >= 3 && c <= 12) begin
        chk("b2b_rsp_write", rsp_write, (k < 5) ? 1 : 0);
        chk("b2b_rsp_rdata", rsp_rdata, (k < 5) ? 0 : 32'h10 + k - 5);
        chk("b2b_rsp_err", rsp_err, 0);
      end
      if (c < 10) begin
        drive(1'b1, c < 5, (c < 5) ? c : c - 5, 32'h10 + c);
        #1;
        chk("b2b_ready", cmd_ready, 1);
      end else begin
        drive(1'b0, 1'b0, '0, '0);
      end
    end
    chk("b2b_busy_end", busy, 0);

    // Seed addr 2 with 0xDEADBEEF
    drive(1'b1, 1'b1, 32'd2, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    chk("seed_rsp", rsp_valid, 1);
    tick();

    // Wait states: read addr 2 (3 low data cycles) with queued write to addr 4
    drive(1'b1, 1'b0, 32'd2, '0);
    tick();
    drive(1'b1, 1'b1, 32'd4, 32'h44);
    #1;
    chk("ws_ready_a", cmd_ready, 1);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_haddr", HADDR, 4);
      chk("ws_htrans", HTRANS, 2'b10);
      chk("ws_ready", cmd_ready, 0);
      chk("ws_rsp_valid", rsp_valid, 0);
      tick();
    end
    HREADY = 1'b1;
    tick();
    chk("ws_rd_valid", rsp_valid, 1);
    chk("ws_rd_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("ws_rd_write", rsp_write, 0);
    chk("ws_hwdata", HWDATA, 32'h44);
    tick();
    chk("ws_wr_valid", rsp_valid, 1);
    chk("ws_wr_write", rsp_write, 1);
    chk("ws_wr_err", rsp_err, 0);
    tick();
    chk("ws_busy", busy, 0);

    // Timeout with MAX_WAIT=4 and a second read pending
    drive(1'b1, 1'b0, 32'd1, '0);
    tick();
    drive(1'b1, 1'b0, 32'd3, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    HREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_rsp_quiet", rsp_valid, 0);
      chk("to_htrans", HTRANS, 2'b10);
      tick();
    end
    chk("to_err1_valid", rsp_valid, 1);
    chk("to_err1_err", rsp_err, 1);
    chk("to_err1_rdata", rsp_rdata, 0);
    chk("to_abort_htrans", HTRANS, 2'b00);
    chk("to_abort_ready", cmd_ready, 0);
    chk("to_abort_busy", busy, 1);
    tick();
    chk("to_err2_valid", rsp_valid, 1);
    chk("to_err2_err", rsp_err, 1);
    chk("to_err2_rdata", rsp_rdata, 0);
    chk("to_busy", busy, 0);
    chk("to_htrans_idle", HTRANS, 2'b00);
    HREADY = 1'b1;
    tick();
    chk("to_rsp_end", rsp_valid, 0);
    drive(1'b1, 1'b1, 32'd5, 32'h55);
    #1;
    chk("to_ready_again", cmd_ready, 1);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    chk("to_new_valid", rsp_valid, 1);
    chk("to_new_err", rsp_err, 0);
    chk("to_new_write", rsp_write, 1);
    tick();

    // Reset mid-stream while FULL
    drive(1'b1, 1'b0, 32'd0, '0);
    tick();
    drive(1'b1, 1'b1, 32'd6, 32'h66);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    chk("mr_full_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mr_ready_in_reset", cmd_ready, 0);
    tick();
    reset = 1'b0;
    chk("mr_htrans", HTRANS, 2'b00);
    chk("mr_haddr", HADDR, 0);
    chk("mr_hwrite", HWRITE, 0);
    chk("mr_hwdata", HWDATA, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_rsp", rsp_valid, 0);
    end
    drive(1'b1, 1'b0, 32'd1, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    chk("mr_rd_htrans", HTRANS, 2'b10);
    tick();
    chk("mr_rd_early", rsp_valid, 0);
    tick();
    chk("mr_rd_valid", rsp_valid, 1);
    chk("mr_rd_rdata", rsp_rdata, 32'h11);
    chk("mr_rd_err", rsp_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
